adsr_envelope: RTL and testbench
================================

Name: adsr_envelope

Overview:
Amplitude stage directly downstream of the oscillators (square/sine). Generates an attack/decay/sustain/release envelope from a note gate and scales the oscillator's signed sample stream by it. The result feeds the synth mixer. Envelope steps advance only on the audio-rate sample tick. The multiply runs every clock.

Parameters:
ENV_WIDTH, 16, envelope level width; unsigned; full scale ENV_MAX = 2^ENV_WIDTH-1
RATE_WIDTH, 16, width of attack/decay/release per-tick step sizes

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; one clock; reset is asynchronous and active-low
sample_tick_in  input  1  one-cycle strobe at audio sample rate; envelope steps only when high
gate_in  input  1  note held (level-sensitive)
attack_rate_in  input  RATE_WIDTH  level increment per tick in ATTACK
decay_rate_in  input  RATE_WIDTH  level decrement per tick in DECAY
sustain_level_in  input  ENV_WIDTH  sustain target level
release_rate_in  input  RATE_WIDTH  level decrement per tick in RELEASE
val_in  input  SYNTH_WIDTH signed  oscillator sample
val_out  output  SYNTH_WIDTH signed  scaled sample
env_out  output  ENV_WIDTH  current envelope level (registered)
active_out  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst_in low, async): state IDLE, level 0, gate_d 0, pipeline regs 0. val_out=0, env_out=0, active_out=0. Reset mid-note aborts immediately. No release.
- Gate edges use registered gate_d. If gate_in is high at reset deassert, it counts as a rise on the first clock.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Priority per clock: gate rise > gate fall > tick step.
- Gate rise, from any state -> ATTACK. Level is kept (retrigger, no click). No level step that cycle even if tick is high.
- Gate fall, from ATTACK/DECAY/SUSTAIN -> RELEASE. Level is kept. No step that cycle.
- Tick steps, computed in ENV_WIDTH+1 bits and saturated:
  - ATTACK: level += attack_rate. If the sum >= ENV_MAX: level = ENV_MAX, go to DECAY.
  - DECAY: next = level - decay_rate. If next <= sustain_level_in (including underflow): level = sustain_level_in, go to SUSTAIN.
  - SUSTAIN: level = sustain_level_in on each tick, so sustain changes track at tick rate.
  - RELEASE: next = level - release_rate. If next <= 0: level = 0, go to IDLE.
  - IDLE: level held at 0.
- Rate 0 means hold: no progress in that state.
- Sustain >= current level on entry to DECAY: exits to SUSTAIN on the first tick.
- Multiply, 2-cycle latency from val_in to val_out (matches the oscillator pipeline depth):
  - Stage 1 registers prod = val_in * signed({1'b0, level}), width SYNTH_WIDTH+ENV_WIDTH+1. The level used is the registered level in the cycle val_in is sampled.
  - Stage 2 registers val_out = prod >>> ENV_WIDTH, truncated to SYNTH_WIDTH. No overflow is possible because the scale is < 1.0.
- env_out equals the internal level register, with no extra latency.
- active_out is decoded from the state register.

Decomposition:
- Add to package constants:
  - env_state_t enum {ENV_IDLE, ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN, ENV_RELEASE}
  - ENV_WIDTH and RATE_WIDTH localparams, so the mixer and control regs share them.
- One sub-module, env_scale: the 2-stage signed multiply/shift.
- Reuse the existing pipeline module only for delay-matching if needed. It is not required here.

Test Plan:
- Reset release with gate_in=1, attack_rate=0x4000, tick every 4 clks -> ATTACK. env_out 0x4000, 0x8000, 0xC000, then 0xFFFF on the 4th tick, then state DECAY.
- Continue with decay_rate=0x1000, sustain=0x8000 -> env steps down by 0x1000 per tick, lands exactly at 0x8000, state SUSTAIN. Then change sustain to 0x6000 -> env_out=0x6000 on the next tick.
- Gate fall in SUSTAIN at 0x6000 with release_rate=0x5000 -> 0x1000, then 0, IDLE, active_out=0.
- val_in=0x5A8279 constant, env held at 0x8000 -> val_out=0x2D413C exactly 2 clocks after env is valid. val_in=0xA57D86 -> val_out=0xD2BEC3.
- Gate re-rise during RELEASE at env=0x3000 -> ATTACK from 0x3000, not 0. A tick in the same cycle as the rise produces no step.
- Drop rst_in asynchronously mid-ATTACK, between clock edges -> all outputs 0 immediately, with no clock needed. State IDLE after release with gate low.

Source files
------------

// File: rtl/adsr_envelope_pkg.sv
// rtl/adsr_envelope_pkg.sv - shared widths, envelope states and helpers for the ADSR amplitude stage
package adsr_envelope_pkg;

  localparam int ENV_WIDTH   = 16;
  localparam int RATE_WIDTH  = 16;
  localparam int SYNTH_WIDTH = 24;

  localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

  typedef enum logic [2:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_DECAY,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_t;

  // One guard bit above the level so steps can detect overflow/underflow.
  function automatic logic [ENV_WIDTH:0] widen_rate(input logic [RATE_WIDTH-1:0] rate);
    return (ENV_WIDTH+1)'(rate);
  endfunction

endpackage

// File: rtl/adsr_envelope_if.sv
// rtl/adsr_envelope_if.sv - control, sample and envelope signals between the synth core and the ADSR stage
interface adsr_envelope_if;
  import adsr_envelope_pkg::*;

  logic                          sample_tick_in;
  logic                          gate_in;
  logic [RATE_WIDTH-1:0]         attack_rate_in;
  logic [RATE_WIDTH-1:0]         decay_rate_in;
  logic [ENV_WIDTH-1:0]          sustain_level_in;
  logic [RATE_WIDTH-1:0]         release_rate_in;
  logic signed [SYNTH_WIDTH-1:0] val_in;
  logic signed [SYNTH_WIDTH-1:0] val_out;
  logic [ENV_WIDTH-1:0]          env_out;
  logic                          active_out;

  modport master (
    output sample_tick_in, gate_in, attack_rate_in, decay_rate_in,
           sustain_level_in, release_rate_in, val_in,
    input  val_out, env_out, active_out
  );

  modport slave (
    input  sample_tick_in, gate_in, attack_rate_in, decay_rate_in,
           sustain_level_in, release_rate_in, val_in,
    output val_out, env_out, active_out
  );

endinterface

// File: rtl/adsr_envelope_env_scale.sv
// rtl/adsr_envelope_env_scale.sv - two-stage signed sample times unsigned envelope multiply
module env_scale
  import adsr_envelope_pkg::*;
(
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic signed [SYNTH_WIDTH-1:0] val,
  input  logic [ENV_WIDTH-1:0]          level,
  output logic signed [SYNTH_WIDTH-1:0] val_out
);

  localparam int PW = SYNTH_WIDTH + ENV_WIDTH + 1;

  logic signed [PW-1:0] val_ext;
  logic signed [PW-1:0] level_ext;
  logic signed [PW-1:0] prod;

  assign val_ext   = {{(ENV_WIDTH+1){val[SYNTH_WIDTH-1]}}, val};
  assign level_ext = {{(SYNTH_WIDTH+1){1'b0}}, level};

  // Envelope scale is below 1.0, so the shifted product always fits SYNTH_WIDTH.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      prod    <= '0;
      val_out <= '0;
    end else begin
      prod    <= val_ext * level_ext;
      val_out <= SYNTH_WIDTH'(prod >>> ENV_WIDTH);
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - ADSR envelope generator driving the oscillator amplitude scaler
module adsr_envelope
  import adsr_envelope_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  adsr_envelope_if.slave   bus
);

  env_state_t           state;
  logic [ENV_WIDTH-1:0] level;
  logic                 gate_d;

  logic                 gate_rise;
  logic                 gate_fall;
  logic [ENV_WIDTH:0]   attack_sum;
  logic [ENV_WIDTH:0]   decay_next;
  logic [ENV_WIDTH:0]   release_next;
  logic                 attack_done;
  logic                 decay_done;
  logic                 release_done;

  assign gate_rise = bus.gate_in & ~gate_d;
  assign gate_fall = ~bus.gate_in & gate_d;

  always_comb begin
    attack_sum   = {1'b0, level} + widen_rate(bus.attack_rate_in);
    decay_next   = {1'b0, level} - widen_rate(bus.decay_rate_in);
    release_next = {1'b0, level} - widen_rate(bus.release_rate_in);
    attack_done  = attack_sum >= {1'b0, ENV_MAX};
    // Guard bit set means the subtraction wrapped below zero.
    decay_done   = decay_next[ENV_WIDTH] || (decay_next[ENV_WIDTH-1:0] <= bus.sustain_level_in);
    release_done = release_next[ENV_WIDTH] || (release_next[ENV_WIDTH-1:0] == '0);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state  <= ENV_IDLE;
      level  <= '0;
      gate_d <= 1'b0;
    end else begin
      gate_d <= bus.gate_in;
      if (gate_rise) begin
        state <= ENV_ATTACK;
      end else if (gate_fall && (state == ENV_ATTACK || state == ENV_DECAY || state == ENV_SUSTAIN)) begin
        state <= ENV_RELEASE;
      end else if (bus.sample_tick_in) begin
        unique case (state)
          ENV_ATTACK: begin
            if (attack_done) begin
              level <= ENV_MAX;
              state <= ENV_DECAY;
            end else begin
              level <= attack_sum[ENV_WIDTH-1:0];
            end
          end
          ENV_DECAY: begin
            if (decay_done) begin
              level <= bus.sustain_level_in;
              state <= ENV_SUSTAIN;
            end else begin
              level <= decay_next[ENV_WIDTH-1:0];
            end
          end
          ENV_SUSTAIN: level <= bus.sustain_level_in;
          ENV_RELEASE: begin
            if (release_done) begin
              level <= '0;
              state <= ENV_IDLE;
            end else begin
              level <= release_next[ENV_WIDTH-1:0];
            end
          end
          ENV_IDLE: level <= '0;
          default: begin
            level <= '0;
            state <= ENV_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.env_out    = level;
  assign bus.active_out = (state != ENV_IDLE);

  env_scale u_env_scale (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .val     (bus.val_in),
    .level   (level),
    .val_out (bus.val_out)
  );

endmodule

// File: tb/tb_adsr_envelope.sv
// tb/tb_adsr_envelope.sv - directed vector bench for the ADSR envelope and amplitude scaler
module tb_adsr_envelope;
  import adsr_envelope_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  adsr_envelope_if bus ();

  adsr_envelope dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic                          gate;
    logic                          tick;
    logic [RATE_WIDTH-1:0]         attack;
    logic [RATE_WIDTH-1:0]         release_r;
    logic [ENV_WIDTH-1:0]          sustain;
    logic signed [SYNTH_WIDTH-1:0] val;
    logic [ENV_WIDTH-1:0]          exp_env;
    logic                          exp_active;
    logic                          chk_val;
    logic signed [SYNTH_WIDTH-1:0] exp_val;
  } vec_t;

  vec_t vecs[40];
  int   n_vecs = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic add_vec(input logic g, input logic t, input logic [15:0] a, input logic [15:0] r,
                         input logic [15:0] s, input logic [23:0] v, input logic [15:0] e,
                         input logic act, input logic cv, input logic [23:0] ev);
    vecs[n_vecs].gate       = g;
    vecs[n_vecs].tick       = t;
    vecs[n_vecs].attack     = a;
    vecs[n_vecs].release_r  = r;
    vecs[n_vecs].sustain    = s;
    vecs[n_vecs].val        = v;
    vecs[n_vecs].exp_env    = e;
    vecs[n_vecs].exp_active = act;
    vecs[n_vecs].chk_val    = cv;
    vecs[n_vecs].exp_val    = ev;
    n_vecs++;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    // Attack from reset with gate already high, then decay to 0x8000.
    add_vec(1, 1, 16'h4000, 16'h5000, 16'h8000, 24'h5A8279, 16'h0000, 1, 0, 0);
    add_vec(1, 1, 16'h4000, 16'h5000, 16'h8000, 24'h5A8279, 16'h4000, 1, 0, 0);
    add_vec(1, 1, 16'h4000, 16'h5000, 16'h8000, 24'h5A8279, 16'h8000, 1, 0, 0);
    add_vec(1, 1, 16'h4000, 16'h5000, 16'h8000, 24'h5A8279, 16'hC000, 1, 0, 0);
    add_vec(1, 1, 16'h4000, 16'h5000, 16'h8000, 24'h5A8279, 16'hFFFF, 1, 0, 0);
    for (int k = 1; k <= 7; k++)
      add_vec(1, 1, 16'h4000, 16'h5000, 16'h8000, 24'h5A8279, 16'(32'hFFFF - k * 32'h1000), 1, 0, 0);
    add_vec(1, 1, 16'h4000, 16'h5000, 16'h8000, 24'h5A8279, 16'h8000, 1, 1, 24'h2D413C);
    add_vec(1, 1, 16'h4000, 16'h5000, 16'h8000, 24'hA57D86, 16'h8000, 1, 1, 24'hD2BEC3);
    add_vec(1, 1, 16'h4000, 16'h5000, 16'h6000, 24'h5A8279, 16'h6000, 1, 1, 24'h21F0ED);
    // Release from sustain, falling edge consumes the tick.
    add_vec(0, 1, 16'h4000, 16'h5000, 16'h6000, 24'h5A8279, 16'h6000, 1, 0, 0);
    add_vec(0, 1, 16'h4000, 16'h5000, 16'h6000, 24'h5A8279, 16'h1000, 1, 0, 0);
    add_vec(0, 1, 16'h4000, 16'h5000, 16'h6000, 24'h5A8279, 16'h0000, 0, 1, 24'h000000);
    add_vec(0, 1, 16'h4000, 16'h5000, 16'h6000, 24'h5A8279, 16'h0000, 0, 0, 0);
    // Retrigger during release keeps the level.
    add_vec(1, 1, 16'h3000, 16'h3000, 16'h6000, 24'h5A8279, 16'h0000, 1, 0, 0);
    add_vec(1, 1, 16'h3000, 16'h3000, 16'h6000, 24'h5A8279, 16'h3000, 1, 0, 0);
    add_vec(1, 1, 16'h3000, 16'h3000, 16'h6000, 24'h5A8279, 16'h6000, 1, 0, 0);
    add_vec(0, 1, 16'h3000, 16'h3000, 16'h6000, 24'h5A8279, 16'h6000, 1, 0, 0);
    add_vec(0, 1, 16'h3000, 16'h3000, 16'h6000, 24'h5A8279, 16'h3000, 1, 0, 0);
    add_vec(1, 1, 16'h3000, 16'h3000, 16'h6000, 24'h5A8279, 16'h3000, 1, 0, 0);
    add_vec(1, 1, 16'h3000, 16'h3000, 16'h6000, 24'h5A8279, 16'h6000, 1, 0, 0);
    add_vec(1, 1, 16'h0000, 16'h3000, 16'h6000, 24'h5A8279, 16'h6000, 1, 0, 0);

    bus.sample_tick_in   = 1'b0;
    bus.gate_in          = 1'b1;
    bus.attack_rate_in   = 16'h4000;
    bus.decay_rate_in    = 16'h1000;
    bus.sustain_level_in = 16'h8000;
    bus.release_rate_in  = 16'h5000;
    bus.val_in           = 24'h5A8279;

    repeat (3) @(posedge clk_in);
    #1;
    check("reset env_out", 32'(bus.env_out), 32'h0);
    check("reset active_out", 32'(bus.active_out), 32'h0);
    check("reset val_out", 32'(bus.val_out), 32'h0);

    @(negedge clk_in);
    rst_in = 1'b1;
    for (int i = 0; i < n_vecs; i++) begin
      bus.gate_in          = vecs[i].gate;
      bus.sample_tick_in   = vecs[i].tick;
      bus.attack_rate_in   = vecs[i].attack;
      bus.release_rate_in  = vecs[i].release_r;
      bus.sustain_level_in = vecs[i].sustain;
      bus.val_in           = vecs[i].val;
      @(posedge clk_in);
      #1;
      check($sformatf("vec%0d env_out", i), 32'(bus.env_out), 32'(vecs[i].exp_env));
      check($sformatf("vec%0d active_out", i), 32'(bus.active_out), 32'(vecs[i].exp_active));
      @(negedge clk_in);
      bus.sample_tick_in = 1'b0;
      repeat (3) @(negedge clk_in);
      if (vecs[i].chk_val)
        check($sformatf("vec%0d val_out", i), 32'(bus.val_out), 32'(vecs[i].exp_val));
    end

    // Asynchronous reset between edges while attacking at 0x6000.
    #2;
    rst_in = 1'b0;
    #1;
    check("async rst env_out", 32'(bus.env_out), 32'h0);
    check("async rst active_out", 32'(bus.active_out), 32'h0);
    check("async rst val_out", 32'(bus.val_out), 32'h0);
    bus.gate_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    bus.sample_tick_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("post rst env_out", 32'(bus.env_out), 32'h0);
    check("post rst active_out", 32'(bus.active_out), 32'h0);
    @(negedge clk_in);
    bus.sample_tick_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
